// File: rtl/router_pkg.sv
// Shared definitions for the router egress arbiter: header layout, port count, FSM states.
package router_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned DEST_W    = 2;
  localparam int unsigned LEN_MSB   = 7;
  localparam int unsigned LEN_LSB   = DEST_W;
  localparam int unsigned REM_W     = 7;
  localparam int unsigned WDOG_W    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StHdrRd,
    StHdrWait,
    StBody
  } arb_state_e;

  // Round-robin successor over the three ports.
  function automatic logic [1:0] port_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/egress_skid_buf.sv
// Two-entry FIFO of {sop, eop, data} feeding the egress stream; head drives the outputs.
module egress_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              push_sop_i,
  input  logic              push_eop_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  localparam int unsigned EntW = DATA_W + 2;

  logic [EntW-1:0] mem_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;
  logic            push_ok;
  logic            pop_ok;
  logic [EntW-1:0] head;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {push_sop_i, push_eop_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Outputs are forced to zero while empty so dout reads 0 after reset.
  assign head    = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign data_o  = valid_o ? head[DATA_W-1:0] : '0;
  assign sop_o   = valid_o && head[DATA_W+1];
  assign eop_o   = valid_o && head[DATA_W];
  assign count_o = count_q;

endmodule

// File: rtl/router_egress_arbiter.sv
// Round-robin packet scheduler draining three FIFOs onto one egress stream, whole packets
// at a time, with a watchdog that aborts packets whose FIFO runs dry.
module router_egress_arbiter
  import router_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_vld_0,
  input  logic              fifo_vld_1,
  input  logic              fifo_vld_2,
  input  logic [DATA_W-1:0] fifo_dout_0,
  input  logic [DATA_W-1:0] fifo_dout_1,
  input  logic [DATA_W-1:0] fifo_dout_2,
  output logic              fifo_rd_0,
  output logic              fifo_rd_1,
  output logic              fifo_rd_2,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              out_ready,
  output logic              sop,
  output logic              eop,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_q, rr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // One-deep record of the read issued last cycle; its data returns this cycle.
  logic              infl_q, infl_d;
  logic              infl_sop_q, infl_sop_d;
  logic              infl_eop_q, infl_eop_d;
  logic [1:0]        infl_port_q, infl_port_d;

  logic [3:0]        vld_vec;
  logic              vld_g;
  logic [DATA_W-1:0] ret_data;
  logic              rd_en;
  logic              rd_sop;
  logic              rd_eop;
  logic              can_rd;
  logic              tmo;
  logic              found;
  logic [1:0]        cand;
  logic [1:0]        buf_count;
  logic              buf_pop;
  logic [2:0]        occ;

  assign vld_vec = {1'b0, fifo_vld_2, fifo_vld_1, fifo_vld_0};
  assign vld_g   = vld_vec[grant_q];

  always_comb begin
    case (infl_port_q)
      2'd0:    ret_data = fifo_dout_0;
      2'd1:    ret_data = fifo_dout_1;
      2'd2:    ret_data = fifo_dout_2;
      default: ret_data = '0;
    endcase
  end

  // Occupancy after this cycle's pop, counting the byte still in flight.
  assign buf_pop = dout_valid && out_ready;
  assign occ     = {1'b0, buf_count} + {2'b00, infl_q} - {2'b00, buf_pop};
  assign can_rd  = vld_g && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    wdog_d  = '0;
    rd_en   = 1'b0;
    rd_sop  = 1'b0;
    rd_eop  = 1'b0;
    tmo     = 1'b0;
    found   = 1'b0;
    cand    = rr_q;
    case (state_q)
      StIdle: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (!found && vld_vec[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
          cand = port_inc(cand);
        end
        if (found) begin
          state_d = StHdrRd;
        end
      end
      StHdrRd: begin
        if (can_rd) begin
          rd_en   = 1'b1;
          rd_sop  = 1'b1;
          state_d = StHdrWait;
        end
      end
      StHdrWait: begin
        rem_d   = REM_W'(ret_data[LEN_MSB:LEN_LSB]) + REM_W'(1);
        state_d = StBody;
      end
      StBody: begin
        if (can_rd) begin
          rd_en = 1'b1;
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            rd_eop  = 1'b1;
            state_d = StIdle;
            rr_d    = port_inc(grant_q);
          end
        end else if (!vld_g && (rem_q != '0)) begin
          if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
            tmo     = 1'b1;
            state_d = StIdle;
            rr_d    = port_inc(grant_q);
          end else begin
            wdog_d = wdog_q + WDOG_W'(1);
          end
        end else begin
          wdog_d = wdog_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign infl_d      = rd_en;
  assign infl_sop_d  = rd_sop;
  assign infl_eop_d  = rd_eop;
  assign infl_port_d = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 2'd0;
      rr_q        <= 2'd0;
      rem_q       <= '0;
      wdog_q      <= '0;
      infl_q      <= 1'b0;
      infl_sop_q  <= 1'b0;
      infl_eop_q  <= 1'b0;
      infl_port_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      rem_q       <= rem_d;
      wdog_q      <= wdog_d;
      infl_q      <= infl_d;
      infl_sop_q  <= infl_sop_d;
      infl_eop_q  <= infl_eop_d;
      infl_port_q <= infl_port_d;
    end
  end

  egress_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (infl_q),
    .push_sop_i  (infl_sop_q),
    .push_eop_i  (infl_eop_q),
    .push_data_i (ret_data),
    .pop_i       (buf_pop),
    .valid_o     (dout_valid),
    .sop_o       (sop),
    .eop_o       (eop),
    .data_o      (dout),
    .count_o     (buf_count)
  );

  assign fifo_rd_0   = rd_en && (grant_q == 2'd0);
  assign fifo_rd_1   = rd_en && (grant_q == 2'd1);
  assign fifo_rd_2   = rd_en && (grant_q == 2'd2);
  assign grant       = grant_q;
  assign timeout_err = tmo;

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: behavioural FIFOs feed the DUT and a byte
// scoreboard checks the egress stream, flags, grants and watchdog timing.
module tb_router_egress_arbiter;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_vld_0, fifo_vld_1, fifo_vld_2;
  logic [7:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
  logic       fifo_rd_0, fifo_rd_1, fifo_rd_2;
  logic [7:0] dout;
  logic       dout_valid;
  logic       out_ready;
  logic       sop, eop;
  logic [1:0] grant;
  logic       timeout_err;

  router_egress_arbiter #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_vld_0  (fifo_vld_0),
    .fifo_vld_1  (fifo_vld_1),
    .fifo_vld_2  (fifo_vld_2),
    .fifo_dout_0 (fifo_dout_0),
    .fifo_dout_1 (fifo_dout_1),
    .fifo_dout_2 (fifo_dout_2),
    .fifo_rd_0   (fifo_rd_0),
    .fifo_rd_1   (fifo_rd_1),
    .fifo_rd_2   (fifo_rd_2),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .out_ready   (out_ready),
    .sop         (sop),
    .eop         (eop),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  logic [7:0] q0[$], q1[$], q2[$];
  logic [9:0] got[$], exp_q[$];
  int         got_cyc[$];
  int         nvec = 0, nmis = 0, cyc = 0;
  int         rd_cnt0 = 0, rd_cnt1 = 0, rd_cnt2 = 0, rd_empty = 0;
  int         tmo_cnt = 0, tmo_cyc = 0, last_rd1 = 0;
  logic       s_valid, s_sop, s_eop, s_tmo;
  logic [7:0] s_dout;
  logic [2:0] s_rd;
  logic [1:0] s_grant;
  bit         refilled;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input int p, input logic [7:0] b);
    case (p)
      0: begin q0.push_back(b); fifo_vld_0 = 1'b1; end
      1: begin q1.push_back(b); fifo_vld_1 = 1'b1; end
      default: begin q2.push_back(b); fifo_vld_2 = 1'b1; end
    endcase
  endtask

  // Loads a packet and appends the bytes it should produce at the egress.
  task automatic load_pkt(input int p, input logic [7:0] hdr, input int npay,
                          input logic [7:0] base, input bit with_par);
    logic [7:0] par = hdr;
    logic [7:0] b;
    push_byte(p, hdr);
    exp_q.push_back({2'b10, hdr});
    for (int i = 0; i < npay; i++) begin
      b = base + 8'(i);
      push_byte(p, b);
      par = par ^ b;
      exp_q.push_back({2'b00, b});
    end
    if (with_par) begin
      push_byte(p, par);
      exp_q.push_back({2'b01, par});
    end
  endtask

  // One clock: sample outputs after the negedge, then model the FIFO pops after the posedge.
  task automatic cycle();
    #1;
    s_valid = dout_valid;
    s_sop   = sop;
    s_eop   = eop;
    s_dout  = dout;
    s_tmo   = timeout_err;
    s_grant = grant;
    s_rd    = {fifo_rd_2, fifo_rd_1, fifo_rd_0};
    if (dout_valid === 1'b1 && out_ready) begin
      got.push_back({sop, eop, dout});
      got_cyc.push_back(cyc);
    end
    if (s_rd[0] === 1'b1) rd_cnt0++;
    if (s_rd[1] === 1'b1) begin rd_cnt1++; last_rd1 = cyc; end
    if (s_rd[2] === 1'b1) rd_cnt2++;
    if (timeout_err === 1'b1) begin tmo_cnt++; tmo_cyc = cyc; end
    @(posedge clk);
    #1;
    if (s_rd[0] === 1'b1) begin
      if (q0.size() > 0) fifo_dout_0 = q0.pop_front(); else rd_empty++;
    end
    if (s_rd[1] === 1'b1) begin
      if (q1.size() > 0) fifo_dout_1 = q1.pop_front(); else rd_empty++;
    end
    if (s_rd[2] === 1'b1) begin
      if (q2.size() > 0) fifo_dout_2 = q2.pop_front(); else rd_empty++;
    end
    fifo_vld_0 = (q0.size() != 0);
    fifo_vld_1 = (q1.size() != 0);
    fifo_vld_2 = (q2.size() != 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      cycle();
      k++;
    end
    repeat (3) cycle();
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  task automatic clear_sb();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    rd_cnt0 = 0;
    rd_cnt1 = 0;
    rd_cnt2 = 0;
    tmo_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    fifo_vld_0 = 1'b0; fifo_vld_1 = 1'b0; fifo_vld_2 = 1'b0;
    fifo_dout_0 = 8'h00; fifo_dout_1 = 8'h00; fifo_dout_2 = 8'h00;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_rd", s_rd, 3'b000);
    chk("rst_grant", s_grant, 2'd0);
    chk("rst_sop_eop", {s_sop, s_eop}, 2'b00);
    chk("rst_dout", s_dout, 8'h00);
    chk("rst_tmo", s_tmo, 1'b0);
    rst = 1'b0;

    // Port 0, len 5: seven reads, seven bytes, one bubble after the header.
    clear_sb();
    load_pkt(0, 8'h14, 5, 8'hA0, 1'b1);
    run_until(7, 40);
    cmp_stream("t1");
    chk("t1_rd0", rd_cnt0, 7);
    chk("t1_rd12", rd_cnt1 + rd_cnt2, 0);
    chk("t1_grant", s_grant, 2'd0);
    chk("t1_tmo", tmo_cnt, 0);
    if (got_cyc.size() == 7) chk("t1_span", got_cyc[6] - got_cyc[0], 7);

    // Round robin across all three ports, then refill 0 and 2 while 2 is served.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_sb();
    load_pkt(0, 8'h08, 2, 8'h10, 1'b1);
    load_pkt(1, 8'h09, 2, 8'h20, 1'b1);
    load_pkt(2, 8'h0A, 2, 8'h30, 1'b1);
    refilled = 1'b0;
    for (int k = 0; k < 200 && got.size() < 20; k++) begin
      cycle();
      if (!refilled && s_grant == 2'd2) begin
        load_pkt(0, 8'h08, 2, 8'h40, 1'b1);
        load_pkt(2, 8'h0A, 2, 8'h50, 1'b1);
        refilled = 1'b1;
      end
    end
    repeat (3) cycle();
    cmp_stream("t2");
    chk("t2_refilled", refilled, 1'b1);
    chk("t2_rd", {rd_cnt0[7:0], rd_cnt1[7:0], rd_cnt2[7:0]}, {8'd8, 8'd4, 8'd8});
    chk("t2_grant", s_grant, 2'd2);

    // Backpressure mid-packet: head frozen, reads stop, nothing lost or duplicated.
    clear_sb();
    load_pkt(0, 8'h18, 6, 8'h60, 1'b1);
    for (int k = 0; k < 40 && got.size() < 3; k++) cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("t3_hold_valid%0d", k), s_valid, 1'b1);
      chk($sformatf("t3_hold_head%0d", k), {s_sop, s_eop, s_dout}, exp_q[3]);
      if (k >= 1) chk($sformatf("t3_hold_rd%0d", k), s_rd, 3'b000);
    end
    out_ready = 1'b1;
    run_until(8, 40);
    cmp_stream("t3");
    chk("t3_rd0", rd_cnt0, 8);
    if (got_cyc.size() == 8) chk("t3_resume", got_cyc[7] - got_cyc[3], 4);

    // Port 1 len 8 with only 3 payload bytes: watchdog aborts, port 2 then port 0 follow.
    clear_sb();
    load_pkt(1, 8'h21, 3, 8'h70, 1'b0);
    for (int k = 0; k < 10 && s_grant !== 2'd1; k++) cycle();
    load_pkt(2, 8'h06, 1, 8'h80, 1'b1);
    load_pkt(0, 8'h04, 1, 8'h90, 1'b1);
    run_until(10, 150);
    cmp_stream("t4");
    chk("t4_tmo_cnt", tmo_cnt, 1);
    chk("t4_tmo_delay", tmo_cyc - last_rd1, TIMEOUT);
    chk("t4_rd1", rd_cnt1, 4);

    // Reset three cycles into a port 2 body; afterwards port 0 wins over port 1.
    clear_sb();
    load_pkt(2, 8'h0E, 3, 8'hB0, 1'b1);
    for (int k = 0; k < 10 && s_rd[2] !== 1'b1; k++) cycle();
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    q2.delete();
    fifo_vld_2 = 1'b0;
    clear_sb();
    cycle();
    chk("t5_valid", s_valid, 1'b0);
    chk("t5_rd", s_rd, 3'b000);
    chk("t5_grant", s_grant, 2'd0);
    load_pkt(0, 8'h00, 0, 8'h00, 1'b1);
    load_pkt(1, 8'h05, 1, 8'hC0, 1'b1);
    run_until(5, 40);
    cmp_stream("t5");

    // Zero-length packet: header then parity only.
    clear_sb();
    load_pkt(1, 8'h01, 0, 8'h00, 1'b1);
    run_until(2, 30);
    cmp_stream("t6");
    chk("t6_rd1", rd_cnt1, 2);
    chk("t6_grant", s_grant, 2'd1);

    chk("rd_while_empty", rd_empty, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
